// File: rtl/vga_pkg.sv
// Shared definitions for the text console: screen geometry defaults,
// controller state encoding and the control codes it recognises.
package vga_pkg;

    localparam int          COLS_DEF  = 160;
    localparam int          ROWS_DEF  = 64;
    localparam logic [7:0]  BLANK_DEF = 8'h20;

    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_FF = 8'h0C;
    localparam logic [7:0]  CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        CLEAR_ROW = 2'd2,
        CLEAR_ALL = 2'd3
    } state_e;

    // Codes that occupy a screen cell (space through tilde).
    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/clear_counter.sv
// Sequences the cells of a blanking pass. col_q/row_q hold the cell the
// controller is currently writing; col_o/row_o give the cell after it and
// done_o flags that the current cell is the final one of the pass.
module clear_counter
    import vga_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       row_only_i,
    input  logic [6:0] start_row_i,
    output logic       done_o,
    output logic [7:0] col_o,
    output logic [6:0] row_o
);

    localparam logic [7:0] COL_MAX = 8'(COLS - 1);
    localparam logic [6:0] ROW_MAX = 7'(ROWS - 1);

    logic [7:0] col_q;
    logic [6:0] row_q;
    logic       active_q;
    logic       row_only_q;
    logic       last_cell;

    assign last_cell = (col_q == COL_MAX) && (row_only_q || (row_q == ROW_MAX));
    assign done_o    = active_q && last_cell;
    assign col_o     = (col_q == COL_MAX) ? 8'd0 : col_q + 8'd1;
    assign row_o     = (col_q == COL_MAX) ? row_q + 7'd1 : row_q;

    // Load on start, then step row-major until the last cell has been written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= 8'd0;
            row_q      <= 7'd0;
            active_q   <= 1'b0;
            row_only_q <= 1'b0;
        end else if (start_i) begin
            col_q      <= 8'd0;
            row_q      <= start_row_i;
            active_q   <= 1'b1;
            row_only_q <= row_only_i;
        end else if (active_q) begin
            if (last_cell) begin
                active_q <= 1'b0;
            end else begin
                col_q <= col_o;
                row_q <= row_o;
            end
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Character-stream console controller: turns a byte stream into screen RAM
// writes, tracks the cursor, and blanks rows/the whole screen on demand.
module text_console_ctrl
    import vga_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  cursor_x,
    output logic [6:0]  cursor_y,
    output logic        busy
);

    localparam logic [7:0] COL_MAX = 8'(COLS - 1);
    localparam logic [6:0] ROW_MAX = 7'(ROWS - 1);

    state_e      state_q;
    logic [7:0]  cursor_x_q;
    logic [6:0]  cursor_y_q;
    logic        wr_en_q;
    logic [14:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        accept;
    logic [6:0]  next_row_d;
    logic        clr_start;
    logic        clr_row_only;
    logic [6:0]  clr_start_row;
    logic        clr_done;
    logic [7:0]  clr_col;
    logic [6:0]  clr_row;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;

    assign next_row_d = (cursor_y_q == ROW_MAX) ? 7'd0 : cursor_y_q + 7'd1;

    // A clear pass starts on LF/FF acceptance or when a write fills the last column.
    assign clr_start     = (accept && ((in_data == CH_LF) || (in_data == CH_FF)))
                         || ((state_q == WRITE) && (cursor_x_q == COL_MAX));
    assign clr_row_only  = !(accept && (in_data == CH_FF));
    assign clr_start_row = clr_row_only ? next_row_d : 7'd0;

    clear_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_clear_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (clr_start),
        .row_only_i  (clr_row_only),
        .start_row_i (clr_start_row),
        .done_o      (clr_done),
        .col_o       (clr_col),
        .row_o       (clr_row)
    );

    // Controller FSM; the write port and cursor are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cursor_x_q <= 8'd0;
            cursor_y_q <= 7'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 15'd0;
            wr_data_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    if (accept) begin
                        if (is_printable(in_data)) begin
                            state_q   <= WRITE;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {cursor_y_q, cursor_x_q};
                            wr_data_q <= in_data;
                        end else if (in_data == CH_LF) begin
                            cursor_x_q <= 8'd0;
                            cursor_y_q <= next_row_d;
                            state_q    <= CLEAR_ROW;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= {next_row_d, 8'd0};
                            wr_data_q  <= BLANK;
                        end else if (in_data == CH_CR) begin
                            cursor_x_q <= 8'd0;
                        end else if (in_data == CH_BS) begin
                            if (cursor_x_q != 8'd0) begin
                                cursor_x_q <= cursor_x_q - 8'd1;
                            end
                        end else if (in_data == CH_FF) begin
                            cursor_x_q <= 8'd0;
                            cursor_y_q <= 7'd0;
                            state_q    <= CLEAR_ALL;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= 15'd0;
                            wr_data_q  <= BLANK;
                        end
                    end
                end
                WRITE: begin
                    if (cursor_x_q == COL_MAX) begin
                        // Line full: wrap and blank the row we move onto.
                        cursor_x_q <= 8'd0;
                        cursor_y_q <= next_row_d;
                        state_q    <= CLEAR_ROW;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= {next_row_d, 8'd0};
                        wr_data_q  <= BLANK;
                    end else begin
                        cursor_x_q <= cursor_x_q + 8'd1;
                        state_q    <= IDLE;
                        wr_en_q    <= 1'b0;
                    end
                end
                CLEAR_ROW, CLEAR_ALL: begin
                    if (clr_done) begin
                        state_q <= IDLE;
                        wr_en_q <= 1'b0;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {clr_row, clr_col};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a write scoreboard and cursor model.
module tb_text_console_ctrl;

    localparam int COLS = 160;
    localparam int ROWS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        busy;

    text_console_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          gaps = 0;
    int          mx = 0;
    int          my = 0;
    logic [14:0] last_addr = 15'd0;
    logic [22:0] exp_q[$];
    logic [22:0] exp_w;

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !wr_en) gaps++;
            if (wr_en) begin
                pulses++;
                last_addr = wr_addr;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_unexpected observed addr=%h data=%h expected no write", wr_addr, wr_data);
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    checks++;
                    assert ({wr_addr, wr_data} === exp_w) else begin
                        errors++;
                        $error("FAIL wr_stream observed addr=%h data=%h expected addr=%h data=%h",
                               wr_addr, wr_data, exp_w[22:8], exp_w[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input int r, input int c, input logic [7:0] d);
        logic [6:0] rr;
        logic [7:0] cc;
        rr = r[6:0];
        cc = c[7:0];
        exp_q.push_back({rr, cc, d});
    endtask

    task automatic model_adv_row();
        my = (my == ROWS - 1) ? 0 : my + 1;
        for (int c = 0; c < COLS; c++) push_w(my, c, 8'h20);
    endtask

    task automatic model(input logic [7:0] code);
        if (code >= 8'h20 && code <= 8'h7E) begin
            push_w(my, mx, code);
            if (mx == COLS - 1) begin
                mx = 0;
                model_adv_row();
            end else begin
                mx++;
            end
        end else if (code == 8'h0A) begin
            mx = 0;
            model_adv_row();
        end else if (code == 8'h0D) begin
            mx = 0;
        end else if (code == 8'h08) begin
            if (mx > 0) mx--;
        end else if (code == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) push_w(r, c, 8'h20);
            mx = 0;
            my = 0;
        end
    endtask

    // Present one code, waiting (bounded) for in_ready; returns just after the accepting edge.
    task automatic send(input logic [7:0] code);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        model(code);
        in_valid = 1'b1;
        in_data  = code;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout_busy", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_x"}, cursor_x, mx);
        chk({tag, "_y"}, cursor_y, my);
    endtask

    int p0;
    int rdy_seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);

        // 'A' accepted on the very first edge after release; write one cycle later
        @(negedge clk);
        rst_n = 1'b1;
        model(8'h41);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("A_wr_en", wr_en, 1);
        chk("A_wr_addr", wr_addr, 15'h0000);
        chk("A_wr_data", wr_data, 8'h41);
        wait_idle();
        chk("A_cursor_x", cursor_x, 1);

        // CR back to column 0, then down to row 5
        send(8'h0D);
        wait_idle();
        chk_cursor("cr");
        for (int i = 0; i < 5; i++) begin
            send(8'h0A);
            wait_idle();
        end
        chk_cursor("lf5");

        // Fill to column 159 of row 5, then 'Z' wraps and blanks row 6
        for (int i = 0; i < COLS - 1; i++) send(8'h61 + 8'(i % 26));
        wait_idle();
        chk_cursor("at_159_5");
        p0 = pulses;
        send(8'h5A);
        wait_idle();
        chk("wrap_pulses", pulses - p0, 1 + COLS);
        chk_cursor("wrap_end");
        chk("wrap_in_ready", in_ready, 1);

        // Down to row 63, column 10, then LF wraps to row 0
        for (int i = 0; i < 57; i++) begin
            send(8'h0A);
            wait_idle();
        end
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
        wait_idle();
        chk_cursor("at_10_63");
        p0 = pulses;
        send(8'h0A);
        wait_idle();
        chk("lfwrap_pulses", pulses - p0, COLS);
        chk_cursor("lfwrap_end");

        // Full clear with in_valid held high during it
        p0 = pulses;
        send(8'h0C);
        rdy_seen = 0;
        in_valid = 1'b1;
        in_data  = 8'h42;
        repeat (100) begin
            @(negedge clk);
            if (in_ready) rdy_seen++;
        end
        in_valid = 1'b0;
        chk("ff_ready_during_clear", rdy_seen, 0);
        wait_idle();
        chk("ff_pulses", pulses - p0, ROWS * COLS);
        chk("ff_last_addr", last_addr, {7'd63, 8'd159});
        chk_cursor("ff_end");

        // BS / BEL / DEL at (0,3): no writes, consumed in one cycle
        for (int i = 0; i < 3; i++) begin
            send(8'h0A);
            wait_idle();
        end
        p0 = pulses;
        send(8'h08);
        @(negedge clk);
        chk("bs_in_ready", in_ready, 1);
        chk("bs_wr_en", wr_en, 0);
        chk_cursor("bs_at0");
        send(8'h07);
        @(negedge clk);
        chk("bel_in_ready", in_ready, 1);
        chk("bel_wr_en", wr_en, 0);
        chk_cursor("bel");
        send(8'h7F);
        @(negedge clk);
        chk("del_in_ready", in_ready, 1);
        chk("ctl_no_pulses", pulses - p0, 0);
        chk_cursor("del");
        send(8'h78);
        send(8'h79);
        send(8'h08);
        wait_idle();
        chk_cursor("bs_mid");

        // Reset in the middle of a full clear
        send(8'h0C);
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cursor_x", cursor_x, 0);
        chk("abort_cursor_y", cursor_y, 0);
        exp_q.delete();
        mx = 0;
        my = 0;
        p0 = pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_writes", pulses - p0, 0);
        chk("abort_in_ready", in_ready, 1);

        chk("strobe_gaps_while_busy", gaps, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
